// File: rtl/mem_wb_if.sv
// mem_wb_if: bundles the M-stage inputs and W-stage write-back outputs
// of mem_wb_stage.
// The master side drives the execute-register outputs and observes
// write-back. The slave side is the stage itself.
interface mem_wb_if;
    logic        reg_write_m;
    logic [1:0]  result_src_m;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_plus4_m;

    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        misalign_w;

    modport master (
        output reg_write_m, result_src_m, mem_write_m, funct3_m,
               alu_result_m, write_data_m, rd_m, pc_plus4_m,
        input  reg_write_w, rd_w, result_w, misalign_w
    );

    modport slave (
        input  reg_write_m, result_src_m, mem_write_m, funct3_m,
               alu_result_m, write_data_m, rd_m, pc_plus4_m,
        output reg_write_w, rd_w, result_w, misalign_w
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back end of the RV32I pipeline.
// Performs loads and stores against a local word-organised DMEM and
// registers the M/W boundary into the write-back triple.
// Optional feature macro: MEMWB_SUBWORD_EN.
// - When defined, byte and half accesses are supported, with alignment
//   checks.
// - When undefined, every access is a word access, and misalign_w stays 0.
module mem_wb_stage #(
    parameter int DMEM_AW = 8
) (
    input  logic     clk,
    input  logic     srst,
    mem_wb_if.slave  bus
);

    localparam int DMEM_WORDS = 2 ** DMEM_AW;

    logic [31:0]        r_dmem [DMEM_WORDS];

    logic               r_regWriteW;
    logic [4:0]         r_rdW;
    logic [31:0]        r_resultW;
    logic               r_misalignW;

    logic [DMEM_AW-1:0] w_wordIdx;
    logic [31:0]        w_readWord;
    logic [31:0]        w_loadData;
    logic [31:0]        w_storeWord;
    logic               w_misaligned;
    logic [31:0]        w_result;

    assign w_wordIdx  = bus.alu_result_m[DMEM_AW+1:2];
    assign w_readWord = r_dmem[w_wordIdx];

`ifdef MEMWB_SUBWORD_EN
    logic [1:0]  w_byteOff;
    logic        w_isMemOp;
    logic [7:0]  w_byteLane;
    logic [15:0] w_halfLane;

    assign w_byteOff = bus.alu_result_m[1:0];
    assign w_isMemOp = bus.mem_write_m | (bus.result_src_m == 2'b01);

    // Load extraction, store lane merge and alignment check, selected by access size
    always_comb begin
        w_misaligned = 1'b0;
        w_loadData   = w_readWord;
        w_storeWord  = bus.write_data_m;
        w_byteLane   = w_readWord[{w_byteOff, 3'b000} +: 8];
        w_halfLane   = w_readWord[{w_byteOff[1], 4'b0000} +: 16];
        case (bus.funct3_m[1:0])
            2'b00: begin
                w_loadData  = bus.funct3_m[2] ? {24'h0, w_byteLane}
                                              : {{24{w_byteLane[7]}}, w_byteLane};
                w_storeWord = w_readWord;
                w_storeWord[{w_byteOff, 3'b000} +: 8] = bus.write_data_m[7:0];
            end
            2'b01: begin
                w_misaligned = w_isMemOp & w_byteOff[0];
                w_loadData   = bus.funct3_m[2] ? {16'h0, w_halfLane}
                                               : {{16{w_halfLane[15]}}, w_halfLane};
                w_storeWord  = w_readWord;
                w_storeWord[{w_byteOff[1], 4'b0000} +: 16] = bus.write_data_m[15:0];
            end
            default: begin
                w_misaligned = w_isMemOp & (w_byteOff != 2'b00);
            end
        endcase
    end
`else
    assign w_misaligned = 1'b0;
    assign w_loadData   = w_readWord;
    assign w_storeWord  = bus.write_data_m;
`endif

    // Write-back source select
    always_comb begin
        w_result = 32'h0;
        case (bus.result_src_m)
            2'b00:   w_result = bus.alu_result_m;
            2'b01:   w_result = w_loadData;
            2'b10:   w_result = bus.pc_plus4_m;
            default: w_result = 32'h0;
        endcase
    end

    // DMEM store port. Contents are never reset, and reset cycles or misaligned accesses do not write.
    always_ff @(posedge clk) begin
        if (!srst && bus.mem_write_m && !w_misaligned) begin
            r_dmem[w_wordIdx] <= w_storeWord;
        end
    end

    // M/W pipeline register. Writes to x0 or misaligned accesses lose their write enable.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_regWriteW <= 1'b0;
            r_rdW       <= 5'd0;
            r_resultW   <= 32'h0;
            r_misalignW <= 1'b0;
        end else begin
            r_regWriteW <= bus.reg_write_m & (bus.rd_m != 5'd0) & ~w_misaligned;
            r_rdW       <= bus.rd_m;
            r_resultW   <= w_result;
            r_misalignW <= w_misaligned;
        end
    end

    assign bus.reg_write_w = r_regWriteW;
    assign bus.rd_w        = r_rdW;
    assign bus.result_w    = r_resultW;
    assign bus.misalign_w  = r_misalignW;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage.
// A byte-addressed reference memory predicts each write-back. The
// monitor compares predictions one cycle later.
module tb_mem_wb_stage;

    localparam int DMEM_AW   = 8;
    localparam int MEM_BYTES = 4 * (2 ** DMEM_AW);

    typedef struct packed {
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        misalign;
    } wb_t;

    logic clk = 1'b0;
    logic srst;

    mem_wb_if bus ();

    mem_wb_stage #(.DMEM_AW(DMEM_AW)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    wb_t        expQ [$];
    logic [7:0] refMem [MEM_BYTES];
    int         vectors     = 0;
    int         miscompares = 0;

    // Drive one M-stage instruction, predict its write-back and update the reference memory
    task automatic applyStimulus(input logic rst, input logic regWrite, input logic [1:0] src,
                                 input logic memWrite, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic [31:0] pc);
        int          size;
        int          base;
        int          a;
        logic [31:0] loadVal;
        logic        mis;
        wb_t         e;
        @(negedge clk);
        srst             = rst;
        bus.reg_write_m  = regWrite;
        bus.result_src_m = src;
        bus.mem_write_m  = memWrite;
        bus.funct3_m     = f3;
        bus.alu_result_m = addr;
        bus.write_data_m = wdata;
        bus.rd_m         = rd;
        bus.pc_plus4_m   = pc;

        a   = int'(addr % MEM_BYTES);
        mis = 1'b0;
`ifdef MEMWB_SUBWORD_EN
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (memWrite || src == 2'b01) && (a % size != 0);
`else
        size = 4;
`endif
        base    = a - (a % size);
        loadVal = 32'h0;
        for (int i = 0; i < size; i++) loadVal = loadVal | (32'(refMem[base + i]) << (8 * i));
        if (size < 4 && !f3[2] && loadVal[8 * size - 1])
            loadVal = loadVal | ~((32'h1 << (8 * size)) - 32'h1);

        if (rst) begin
            e = '0;
        end else begin
            e.regWrite = regWrite && (rd != 5'd0) && !mis;
            e.rd       = rd;
            e.misalign = mis;
            case (src)
                2'b00:   e.result = addr;
                2'b01:   e.result = loadVal;
                2'b10:   e.result = pc;
                default: e.result = 32'h0;
            endcase
            if (memWrite && !mis)
                for (int i = 0; i < size; i++) refMem[base + i] = wdata[8 * i +: 8];
        end
        expQ.push_back(e);
    endtask

    // Compare one observed write-back triple against its prediction
    task automatic checkOutput(input wb_t e);
        vectors++;
        if (bus.reg_write_w !== e.regWrite || bus.rd_w !== e.rd ||
            bus.result_w !== e.result || bus.misalign_w !== e.misalign) begin
            miscompares++;
            $display("[TB] FAIL wb vector %0d: got rw=%0b rd=%0d res=%h mis=%0b, expected rw=%0b rd=%0d res=%h mis=%0b",
                     vectors, bus.reg_write_w, bus.rd_w, bus.result_w, bus.misalign_w,
                     e.regWrite, e.rd, e.result, e.misalign);
        end
    endtask

    // Monitor: after each active edge, pop the oldest prediction and check the W outputs
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Stimulus: reset, memory fill, directed cases, then randomized traffic
    initial begin
        int guard;
        srst             = 1'b1;
        bus.reg_write_m  = 1'b0;
        bus.result_src_m = 2'b00;
        bus.mem_write_m  = 1'b0;
        bus.funct3_m     = 3'b010;
        bus.alu_result_m = 32'h0;
        bus.write_data_m = 32'h0;
        bus.rd_m         = 5'd0;
        bus.pc_plus4_m   = 32'h0;

        repeat (2) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0);

        for (int w = 0; w < 2 ** DMEM_AW; w++)
            applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'(w * 4), $urandom(), 5'd0, 32'h0);

        // Reset must clear outputs and drop the store
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h80, 32'h0, 5'd0, 32'h0);
        repeat (2) applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 3'b010, 32'h80, 32'hCAFE_BABE, 5'd5, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h80, 32'h0, 5'd9, 32'h0);

        // ALU write-back and x0 suppression
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd3, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 32'h0);

        // Back-to-back store/load word
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd7, 32'h0);

        // Subword stores and loads
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h40, 32'h0, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 32'h41, 32'h0000_0080, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b000, 32'h41, 32'h0, 5'd8, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b100, 32'h41, 32'h0, 5'd8, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 32'h42, 32'h0000_A5A5, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8, 32'h0);

        // Misaligned load and store
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h42, 32'h0, 5'd4, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h43, 32'hFFFF_FFFF, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd4, 32'h0);

        // pc+4 select and address wrap
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 3'b000, 32'h0, 32'h0, 5'd2, 32'h104);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 3'b010, 32'h400, 32'h1357_9BDF, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, 32'h000, 32'h0, 5'd6, 32'h0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++)
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom()), 2'($urandom()),
                          ($urandom_range(0, 2) == 0), 3'($urandom()), $urandom(), $urandom(),
                          5'($urandom()), $urandom());

        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
